// File: rtl/prime_sieve.sv
// Sieve of Eratosthenes engine: sole master of a 256 x 8 synchronous RAM.
// Leaves mem[n] = 1 for prime n and 0 otherwise, then raises done and releases the bus.
module prime_sieve #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] out__addr,
    output logic              out__wr,
    input  logic [DATA_W-1:0] in__din,
    output logic [DATA_W-1:0] out__dout,
    output logic              out__rdy,
    output logic              out__done
);

    localparam int P_W = ADDR_W / 2 + 1;
    localparam int M_W = ADDR_W + 1;

    localparam logic [ADDR_W-1:0] A_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_LAST  = '1;
    localparam logic [ADDR_W-1:0] A_FIRST = ADDR_W'(2);
    localparam logic [P_W-1:0]    P_ONE   = P_W'(1);
    localparam logic [P_W-1:0]    P_FIRST = P_W'(2);
    // Once p*p exceeds the table, every composite has already been struck out.
    localparam logic [P_W-1:0]    P_STOP  = P_W'(1 << (ADDR_W / 2));
    localparam logic [M_W-1:0]    M_MAX   = M_W'((1 << ADDR_W) - 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_RD,
        S_CHK,
        S_MARK,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic [P_W-1:0]    p_q, p_d;
    logic [M_W-1:0]    m_q, m_d;
    logic              go_q, go_d;

    logic [M_W-1:0]    m_sq;
    logic [M_W-1:0]    m_nxt;

    // go_q keeps the bus quiet for the cycles reset is held, even though state sits in INIT.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_INIT;
            a_q     <= '0;
            p_q     <= P_FIRST;
            m_q     <= '0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            p_q     <= p_d;
            m_q     <= m_d;
            go_q    <= go_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        p_d     = p_q;
        m_d     = m_q;
        go_d    = 1'b1;
        // m is one bit wider than the address so a stride past the top never wraps low.
        m_sq    = M_W'(p_q) * M_W'(p_q);
        m_nxt   = m_q + M_W'(p_q);
        unique case (state_q)
            S_INIT: begin
                if (go_q) begin
                    a_d = a_q + A_ONE;
                    if (a_q == A_LAST) begin
                        state_d = S_RD;
                        p_d     = P_FIRST;
                    end
                end
            end
            S_RD: begin
                state_d = (p_q == P_STOP) ? S_DONE : S_CHK;
            end
            S_CHK: begin
                if (in__din != '0) begin
                    state_d = S_MARK;
                    m_d     = m_sq;
                end else begin
                    p_d     = p_q + P_ONE;
                    state_d = S_RD;
                end
            end
            S_MARK: begin
                m_d = m_nxt;
                if (m_nxt > M_MAX) begin
                    p_d     = p_q + P_ONE;
                    state_d = S_RD;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    always_comb begin
        out__addr = '0;
        out__wr   = 1'b0;
        out__dout = '0;
        out__rdy  = 1'b0;
        out__done = 1'b0;
        unique case (state_q)
            S_INIT: begin
                out__addr = go_q ? a_q : '0;
                out__wr   = go_q;
                out__dout = DATA_W'(go_q && (a_q >= A_FIRST));
            end
            S_RD: begin
                out__addr = ADDR_W'(p_q);
            end
            S_CHK: begin
                out__addr = ADDR_W'(p_q);
            end
            S_MARK: begin
                out__addr = m_q[ADDR_W-1:0];
                out__wr   = 1'b1;
            end
            S_DONE: begin
                out__rdy  = 1'b1;
                out__done = 1'b1;
            end
            default: begin
                out__addr = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_prime_sieve.sv
// Bench for prime_sieve: behavioural RAM, trial-division reference table,
// spot-check vector table, and reset-abort scenarios at fixed and random points.
module tb_prime_sieve;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] out__addr;
    logic       out__wr;
    logic [7:0] in__din;
    logic [7:0] out__dout;
    logic       out__rdy;
    logic       out__done;

    prime_sieve #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .out__addr (out__addr),
        .out__wr   (out__wr),
        .in__din   (in__din),
        .out__dout (out__dout),
        .out__rdy  (out__rdy),
        .out__done (out__done)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:255];
    bit         scramble = 1'b0;

    always @(posedge clk) begin
        if (scramble) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'($urandom);
        end else if (out__wr) begin
            mem[out__addr] <= out__dout;
        end
        in__din <= mem[out__addr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model from the definition of a prime, not from the sieve's mechanics.
    logic [7:0] exp_tab [0:255];
    int         exp_marks [$];
    int         exp_ones;

    function automatic bit is_prime(input int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= n; d++) if (n % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic build_model();
        exp_ones = 0;
        exp_marks.delete();
        for (int n = 0; n < 256; n++) begin
            exp_tab[n] = is_prime(n) ? 8'h01 : 8'h00;
            if (is_prime(n)) exp_ones++;
        end
        for (int p = 2; p * p < 256; p++)
            if (is_prime(p))
                for (int m = p * p; m < 256; m += p) exp_marks.push_back(m);
    endtask

    typedef struct {
        int         n;
        logic [7:0] v;
    } spot_t;

    spot_t spots [9];

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t wq [$];

    task automatic hold_reset(input int cycles);
        int errs;
        errs = 0;
        @(negedge clk);
        rst      = 1'b0;
        scramble = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            scramble = 1'b0;
            if (out__wr !== 1'b0 || out__addr !== 8'h00 || out__dout !== 8'h00 ||
                out__rdy !== 1'b0 || out__done !== 1'b0) errs++;
        end
        check("reset_outputs_quiet", errs, 0);
        rst = 1'b1;
    endtask

    task automatic run_collect(output int ncyc);
        wq.delete();
        ncyc = 0;
        forever begin
            @(negedge clk);
            if (out__done === 1'b1 || ncyc >= 2000) break;
            if (out__wr === 1'b1) wq.push_back('{a: out__addr, d: out__dout});
            ncyc++;
        end
        check("done_before_timeout", (ncyc < 2000), 1);
    endtask

    task automatic verify_run(input string tag, input int ncyc);
        int errs, ones, min_a;
        check({tag, "_done_latency_in_589_591"}, (ncyc >= 589 && ncyc <= 591), 1);
        check({tag, "_rdy_with_done"}, out__rdy, 1);
        check({tag, "_wr_low_at_done"}, out__wr, 0);
        errs = 0;
        for (int i = 0; i < 256; i++)
            if (i >= wq.size() || wq[i].a !== 8'(i) || wq[i].d !== ((i >= 2) ? 8'h01 : 8'h00)) errs++;
        check({tag, "_init_write_errs"}, errs, 0);
        check({tag, "_mark_write_count"}, wq.size() - 256, exp_marks.size());
        errs  = 0;
        min_a = 256;
        for (int i = 256; i < wq.size(); i++) begin
            if (i - 256 >= exp_marks.size() || int'(wq[i].a) != exp_marks[i - 256] || wq[i].d !== 8'h00) errs++;
            if (int'(wq[i].a) < min_a) min_a = int'(wq[i].a);
        end
        check({tag, "_mark_seq_errs"}, errs, 0);
        check({tag, "_mark_min_addr_ge4"}, (min_a >= 4), 1);
        if (wq.size() >= 258) begin
            check({tag, "_first_mark_addr"}, wq[256].a, 4);
            check({tag, "_mark_step"}, wq[257].a - wq[256].a, 2);
        end else begin
            check({tag, "_enough_mark_writes"}, wq.size(), 258);
        end
        errs = 0;
        ones = 0;
        for (int n = 0; n < 256; n++) begin
            if (mem[n] !== exp_tab[n]) errs++;
            if (mem[n] === 8'h01) ones++;
        end
        check({tag, "_table_errs"}, errs, 0);
        check({tag, "_prime_count"}, ones, exp_ones);
        foreach (spots[k]) check($sformatf("%s_mem[%0d]", tag, spots[k].n), mem[spots[k].n], spots[k].v);
    endtask

    logic [7:0] snap [0:255];

    initial begin
        int ncyc, errs, wcount, p3_addr;
        bit found;

        spots = '{'{2, 8'h01}, '{3, 8'h01}, '{97, 8'h01}, '{251, 8'h01},
                  '{0, 8'h00}, '{1, 8'h00}, '{4, 8'h00}, '{225, 8'h00}, '{255, 8'h00}};
        build_model();

        // Reset held, then a clean full run.
        hold_reset(3);
        run_collect(ncyc);
        verify_run("run1", ncyc);

        // Idle after completion: flags sticky, bus quiet, table untouched.
        for (int n = 0; n < 256; n++) snap[n] = mem[n];
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out__done !== 1'b1 || out__rdy !== 1'b1 || out__wr !== 1'b0) errs++;
        end
        check("idle_after_done_errs", errs, 0);
        errs = 0;
        for (int n = 0; n < 256; n++) if (mem[n] !== snap[n]) errs++;
        check("idle_ram_unchanged_errs", errs, 0);

        // Abort inside the p=3 marking pass, then restart.
        hold_reset(2);
        wcount  = 0;
        found   = 1'b0;
        p3_addr = 0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (out__wr === 1'b1) begin
                wcount++;
                if (wcount == 256 + 126 + 1) begin
                    found   = 1'b1;
                    p3_addr = int'(out__addr);
                end
            end
        end
        check("reached_p3_mark", found, 1);
        check("p3_first_mark_addr", p3_addr, 9);
        repeat (5) @(negedge clk);
        hold_reset(2);
        run_collect(ncyc);
        verify_run("abort_p3", ncyc);

        // Random abort points across the whole run, including after done.
        for (int r = 0; r < 3; r++) begin
            hold_reset(2 + int'($urandom_range(0, 3)));
            repeat (int'($urandom_range(0, 620))) @(negedge clk);
        end
        hold_reset(2);
        run_collect(ncyc);
        verify_run("rand_abort", ncyc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
